// File: rtl/bmac_acc_pipe.sv
// Streaming binary MAC: XNOR, mask, chunked popcount and saturating accumulate over
// multi-beat vectors. The result leaves on a valid/ready channel.
module bmac_acc_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int LUT_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter bit BIPOLAR   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_a,
  input  logic [IN_WIDTH-1:0]  in_b,
  input  logic [IN_WIDTH-1:0]  in_mask,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat
);
  localparam int NCHUNK = IN_WIDTH / LUT_WIDTH;
  localparam int PW     = $clog2(IN_WIDTH + 1);
  localparam int CW     = $clog2(LUT_WIDTH + 1);
  localparam int AW1    = ACC_WIDTH + 1;

  function automatic logic [PW-1:0] pop_word(input logic [IN_WIDTH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < IN_WIDTH; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  function automatic logic [CW-1:0] pop_chunk(input logic [LUT_WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LUT_WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Bipolar sums are signed: out of range when the two top bits disagree.
  // Unipolar sums are never negative, so only the carry bit can overflow.
  function automatic logic is_clamped(input logic signed [AW1-1:0] s);
    if (BIPOLAR) return s[AW1-1] ^ s[AW1-2];
    return s[AW1-1];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sat_val(input logic signed [AW1-1:0] s);
    if (!is_clamped(s)) return s[ACC_WIDTH-1:0];
    if (!BIPOLAR) return '1;
    return s[AW1-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction

  logic                        stall;
  logic                        vld_p0, vld_p1, vld_p2;
  logic [IN_WIDTH-1:0]         x_p0;
  logic [PW-1:0]               nb_p0, nb_p1, nb_p2;
  logic                        last_p0, last_p1, last_p2;
  logic [CW-1:0]               chunk_p1 [NCHUNK];
  logic [PW-1:0]               pop_p2;
  logic [PW-1:0]               pop_sum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        first, sat_sticky;
  logic signed [AW1-1:0]       contrib, base, sum;
  logic                        clamp;
  logic [ACC_WIDTH-1:0]        sum_sat;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    pop_sum = '0;
    for (int k = 0; k < NCHUNK; k++) pop_sum = pop_sum + PW'(chunk_p1[k]);
  end

  always_comb begin
    contrib = AW1'(pop_p2);
    if (BIPOLAR) contrib = (AW1'(pop_p2) << 1) - AW1'(nb_p2);
    base = '0;
    if (!first) base = BIPOLAR ? AW1'(acc) : AW1'($unsigned(acc));
    sum     = base + contrib;
    clamp   = is_clamped(sum);
    sum_sat = sat_val(sum);
  end

  // p0: XNOR/mask and active-bit count; p1: per-chunk counts; p2: summed count
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) begin
        x_p0    <= ~(in_a ^ in_b) & in_mask;
        nb_p0   <= pop_word(in_mask);
        last_p0 <= in_last;
      end
      if (vld_p0) begin
        for (int k = 0; k < NCHUNK; k++)
          chunk_p1[k] <= pop_chunk(x_p0[k*LUT_WIDTH +: LUT_WIDTH]);
        nb_p1   <= nb_p0;
        last_p1 <= last_p0;
      end
      if (vld_p1) begin
        pop_p2  <= pop_sum;
        nb_p2   <= nb_p1;
        last_p2 <= last_p1;
      end
    end
  end

  // Accumulate stage and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      acc        <= '0;
      first      <= 1'b1;
      sat_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else if (!stall) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= 1'b0;
      if (vld_p2) begin
        if (last_p2) begin
          out_data   <= sum_sat;
          out_sat    <= sat_sticky | clamp;
          out_valid  <= 1'b1;
          first      <= 1'b1;
          sat_sticky <= 1'b0;
        end else begin
          acc        <= $signed(sum_sat);
          first      <= 1'b0;
          sat_sticky <= sat_sticky | clamp;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmac_acc_pipe.sv
// Directed bench for bmac_acc_pipe: three instances (default, 8-bit accumulator,
// unipolar) share one input stream; results are captured at handshake and compared.
module tb_bmac_acc_pipe;
  logic        clk, rst, in_valid, in_last, out_ready;
  logic [31:0] in_a, in_b, in_mask;
  logic        rdy_m, rdy_s, rdy_u;
  logic        vld_m, vld_s, vld_u;
  logic [15:0] data_m, data_u;
  logic [7:0]  data_s;
  logic        sat_m, sat_s, sat_u;

  int checks = 0;
  int errors = 0;

  logic [15:0] qd_m[$], qd_s[$], qd_u[$];
  logic        qs_m[$], qs_s[$], qs_u[$];

  bmac_acc_pipe u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_a(in_a), .in_b(in_b),
    .in_mask(in_mask), .in_last(in_last), .out_valid(vld_m), .out_ready(out_ready),
    .out_data(data_m), .out_sat(sat_m));

  bmac_acc_pipe #(.ACC_WIDTH(8)) u_acc8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_a(in_a), .in_b(in_b),
    .in_mask(in_mask), .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready),
    .out_data(data_s), .out_sat(sat_s));

  bmac_acc_pipe #(.BIPOLAR(1'b0)) u_uni (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .in_a(in_a), .in_b(in_b),
    .in_mask(in_mask), .in_last(in_last), .out_valid(vld_u), .out_ready(out_ready),
    .out_data(data_u), .out_sat(sat_u));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each result that will be accepted at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (vld_m) begin qd_m.push_back(data_m); qs_m.push_back(sat_m); end
      if (vld_s) begin qd_s.push_back({8'h00, data_s}); qs_s.push_back(sat_s); end
      if (vld_u) begin qd_u.push_back(data_u); qs_u.push_back(sat_u); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] m, input logic last);
    int n;
    n = 0;
    in_a = a; in_b = b; in_mask = m; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_m) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: in_ready got 0, required 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // inst: 0 = default, 1 = 8-bit accumulator, 2 = unipolar
  task automatic expect_res(input string name, input int inst, input logic [15:0] d,
                            input logic s);
    logic [15:0] gd;
    logic        gs;
    int          sz;
    sz = (inst == 0) ? qd_m.size() : (inst == 1) ? qd_s.size() : qd_u.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no result, required %0h", name, d);
    end else begin
      case (inst)
        0:       begin gd = qd_m.pop_front(); gs = qs_m.pop_front(); end
        1:       begin gd = qd_s.pop_front(); gs = qs_s.pop_front(); end
        default: begin gd = qd_u.pop_front(); gs = qs_u.pop_front(); end
      endcase
      chk({name, "_data"}, {16'h0, gd}, {16'h0, d});
      chk({name, "_sat"}, {31'h0, gs}, {31'h0, s});
    end
  endtask

  task automatic expect_all(input string name, input logic [15:0] dm, input logic sm,
                            input logic [15:0] ds, input logic ss,
                            input logic [15:0] du, input logic su);
    expect_res({name, "_main"}, 0, dm, sm);
    expect_res({name, "_acc8"}, 1, ds, ss);
    expect_res({name, "_uni"}, 2, du, su);
  endtask

  typedef struct {
    logic [31:0] a, b, mask;
    logic        last;
    logic [15:0] exp_m, exp_u;
  } beat_t;

  beat_t tbl[10];

  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 16'h0020, 16'h0020};
    tbl[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 16'hFFE0, 16'h0000};
    tbl[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 16'h0000, 16'h0000};
    tbl[3] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFFF_FFFF, 1'b1, 16'h0000, 16'h0010};
    tbl[4] = '{32'h0000_000F, 32'h0000_0003, 32'h0000_00FF, 1'b1, 16'h0004, 16'h0006};
    tbl[5] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_FFFF, 1'b1, 16'h0010, 16'h0020};
    tbl[7] = '{32'h1111_1111, 32'h1111_1111, 32'hFFFF_FFFF, 1'b0, 16'h0000, 16'h0000};
    tbl[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 16'h0000, 16'h0000};
    tbl[9] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b1, 16'h0018, 16'h0020};

    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; in_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'h0, vld_m}, 32'h0);
    chk("reset_out_data", {16'h0, data_m}, 32'h0);
    chk("reset_out_sat", {31'h0, sat_m}, 32'h0);
    chk("reset_in_ready", {31'h0, rdy_m}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: result appears after the third edge following acceptance
    drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_valid_edge%0d", k), {31'h0, vld_m}, {31'h0, (k == 3)});
    end
    chk("latency_data", {16'h0, data_m}, 32'h0020);
    chk("latency_sat", {31'h0, sat_m}, 32'h0);
    repeat (4) @(posedge clk); #1;
    expect_all("lat", 16'h0020, 1'b0, 16'h0020, 1'b0, 16'h0020, 1'b0);

    // Back-to-back table stream
    for (int i = 0; i < 10; i++)
      drive_beat(tbl[i].a, tbl[i].b, tbl[i].mask, tbl[i].last);
    repeat (8) @(posedge clk); #1;
    for (int i = 0; i < 10; i++)
      if (tbl[i].last)
        expect_all($sformatf("tbl%0d", i), tbl[i].exp_m, 1'b0,
                   {8'h00, tbl[i].exp_m[7:0]}, 1'b0, tbl[i].exp_u, 1'b0);

    // Output stall with three single-beat vectors in flight
    out_ready = 1'b0;
    fork
      begin
        drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive_beat(32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      end
      begin
        repeat (6) @(posedge clk); #1;
        chk("stall_in_ready", {31'h0, rdy_m}, 32'h0);
        chk("stall_out_valid", {31'h0, vld_m}, 32'h1);
        chk("stall_hold_data", {16'h0, data_m}, 32'h0020);
        @(posedge clk); #1;
        chk("stall_hold_data2", {16'h0, data_m}, 32'h0020);
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #1;
    expect_all("stall0", 16'h0020, 1'b0, 16'h0020, 1'b0, 16'h0020, 1'b0);
    expect_all("stall1", 16'hFFE0, 1'b0, 16'h00E0, 1'b0, 16'h0000, 1'b0);
    expect_all("stall2", 16'h0020, 1'b0, 16'h0020, 1'b0, 16'h0020, 1'b0);

    // Saturation in the 8-bit accumulator, then a clean vector
    for (int i = 0; i < 5; i++)
      drive_beat(32'h0F0F_3C3C, 32'h0F0F_3C3C, 32'hFFFF_FFFF, (i == 4));
    drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    repeat (8) @(posedge clk); #1;
    expect_all("satv", 16'h00A0, 1'b0, 16'h007F, 1'b1, 16'h00A0, 1'b0);
    expect_all("post_sat", 16'h0020, 1'b0, 16'h0020, 1'b0, 16'h0020, 1'b0);

    // Partial mask, eight active bits
    drive_beat(32'h1234_5678, 32'h1234_5678, 32'h0000_00FF, 1'b1);
    repeat (8) @(posedge clk); #1;
    expect_all("mask8", 16'h0008, 1'b0, 16'h0008, 1'b0, 16'h0008, 1'b0);

    // Reset in the middle of a vector discards it
    drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, vld_m}, 32'h0);
    chk("midrst_out_data", {16'h0, data_m}, 32'h0);
    chk("midrst_out_sat", {31'h0, sat_m}, 32'h0);
    chk("midrst_in_ready", {31'h0, rdy_m}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    drive_beat(32'h5555_AAAA, 32'h5555_AAAA, 32'hFFFF_FFFF, 1'b1);
    repeat (8) @(posedge clk); #1;
    expect_all("after_rst", 16'h0020, 1'b0, 16'h0020, 1'b0, 16'h0020, 1'b0);
    chk("no_extra_results", qd_m.size() + qd_s.size() + qd_u.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
